// File: rtl/piradspi_resp_tracker.sv
// Response tracker: matches engine response headers against accepted commands,
// strips the header and forwards the data words tagged with id and tlast.

package piradspi_pkg;
    localparam int unsigned CMD_ID_WIDTH = 8;
    localparam int unsigned MAGIC_WIDTH  = 8;
    localparam logic [MAGIC_WIDTH-1:0] RESPONSE_MAGIC = 8'hA5;
    typedef logic [15:0] xfer_len_t;
endpackage

module piradspi_resp_tracker
    import piradspi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TRK_DEPTH  = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             trk_valid,
    output logic                             trk_ready,
    input  logic [CMD_ID_WIDTH-1:0]          trk_id,
    input  logic [$bits(xfer_len_t)-1:0]     trk_len,
    input  logic [DATA_WIDTH-1:0]            s_miso_tdata,
    input  logic                             s_miso_tvalid,
    output logic                             s_miso_tready,
    output logic [DATA_WIDTH-1:0]            m_data_tdata,
    output logic                             m_data_tvalid,
    input  logic                             m_data_tready,
    output logic                             m_data_tlast,
    output logic [CMD_ID_WIDTH-1:0]          m_data_tid,
    output logic                             resp_done,
    output logic [CMD_ID_WIDTH-1:0]          resp_done_id,
    output logic                             resp_error,
    output logic [1:0]                       err_code,
    output logic [15:0]                      err_count,
    output logic [$clog2(TRK_DEPTH+1)-1:0]   outstanding
);

    localparam int unsigned LEN_W   = $bits(xfer_len_t);
    localparam int unsigned WORDS_W = LEN_W + 1;
    localparam int unsigned PTR_W   = $clog2(TRK_DEPTH);
    localparam int unsigned CNT_W   = $clog2(TRK_DEPTH + 1);
    localparam int unsigned SHIFT   = $clog2(DATA_WIDTH);

    localparam logic [1:0] ERR_MAGIC  = 2'd1;
    localparam logic [1:0] ERR_ID     = 2'd2;
    localparam logic [1:0] ERR_ORPHAN = 2'd3;

    if (DATA_WIDTH < MAGIC_WIDTH + CMD_ID_WIDTH || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0)
    begin : g_bad_data_width
        $error("DATA_WIDTH must be a power of two holding magic and id");
    end

    typedef enum logic {
        S_HDR,
        S_DATA
    } state_t;

    logic [CMD_ID_WIDTH-1:0] id_mem  [TRK_DEPTH];
    xfer_len_t               len_mem [TRK_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;

    state_t                  state;
    logic [WORDS_W-1:0]      remaining;
    logic [CMD_ID_WIDTH-1:0] cur_id;

    logic [MAGIC_WIDTH-1:0]  hdr_magic;
    logic [CMD_ID_WIDTH-1:0] hdr_id;
    logic [WORDS_W-1:0]      hdr_words;
    logic                    push;
    logic                    pop;
    logic                    hdr_fire;
    logic                    data_fire;
    logic                    fifo_empty;
    logic                    magic_ok;
    logic                    err_fire;
    logic [1:0]              err_nxt;

    assign hdr_magic  = s_miso_tdata[DATA_WIDTH-1 -: MAGIC_WIDTH];
    assign hdr_id     = s_miso_tdata[DATA_WIDTH-MAGIC_WIDTH-1 -: CMD_ID_WIDTH];
    assign magic_ok   = (hdr_magic == RESPONSE_MAGIC);

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign trk_ready  = (count != CNT_W'(TRK_DEPTH));
    assign outstanding = count;
    assign fifo_empty = (count == '0);
    assign push       = trk_valid && trk_ready;

    assign hdr_fire   = (state == S_HDR) && s_miso_tvalid;
    assign data_fire  = (state == S_DATA) && s_miso_tvalid && m_data_tready;
    assign pop        = hdr_fire && magic_ok && !fifo_empty;

    assign hdr_words  = (WORDS_W'(len_mem[rd_ptr]) + WORDS_W'(DATA_WIDTH - 1)) >> SHIFT;

    assign s_miso_tready = (state == S_HDR) || m_data_tready;
    assign m_data_tvalid = (state == S_DATA) && s_miso_tvalid;
    assign m_data_tdata  = s_miso_tdata;
    assign m_data_tlast  = (state == S_DATA) && (remaining == WORDS_W'(1));
    assign m_data_tid    = cur_id;

    always_comb begin
        err_fire = 1'b0;
        err_nxt  = '0;
        if (hdr_fire) begin
            if (!magic_ok) begin
                err_fire = 1'b1;
                err_nxt  = ERR_MAGIC;
            end else if (fifo_empty) begin
                err_fire = 1'b1;
                err_nxt  = ERR_ORPHAN;
            end else if (hdr_id != id_mem[rd_ptr]) begin
                err_fire = 1'b1;
                err_nxt  = ERR_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]  <= trk_id;
            len_mem[wr_ptr] <= trk_len;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_error <= 1'b0;
            err_code   <= '0;
            err_count  <= '0;
        end else begin
            resp_error <= err_fire;
            if (err_fire) begin
                err_code <= err_nxt;
                if (err_count != '1) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_HDR;
            remaining    <= '0;
            cur_id       <= '0;
            resp_done    <= 1'b0;
            resp_done_id <= '0;
        end else begin
            resp_done <= 1'b0;
            case (state)
                S_HDR: begin
                    // An id mismatch still consumes the head entry; the received id tags the data.
                    if (pop) begin
                        cur_id <= hdr_id;
                        if (hdr_words == '0) begin
                            resp_done    <= 1'b1;
                            resp_done_id <= hdr_id;
                        end else begin
                            remaining <= hdr_words;
                            state     <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_fire) begin
                        remaining <= remaining - WORDS_W'(1);
                        if (remaining == WORDS_W'(1)) begin
                            resp_done    <= 1'b1;
                            resp_done_id <= cur_id;
                            state        <= S_HDR;
                        end
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_piradspi_resp_tracker.sv
// Randomised bench for piradspi_resp_tracker against a queue-based reference model.

module tb_piradspi_resp_tracker;
    import piradspi_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        trk_valid;
    logic        trk_ready;
    logic [7:0]  trk_id;
    logic [15:0] trk_len;
    logic [31:0] s_miso_tdata;
    logic        s_miso_tvalid;
    logic        s_miso_tready;
    logic [31:0] m_data_tdata;
    logic        m_data_tvalid;
    logic        m_data_tready;
    logic        m_data_tlast;
    logic [7:0]  m_data_tid;
    logic        resp_done;
    logic [7:0]  resp_done_id;
    logic        resp_error;
    logic [1:0]  err_code;
    logic [15:0] err_count;
    logic [4:0]  outstanding;

    piradspi_resp_tracker #(.DATA_WIDTH(32), .TRK_DEPTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .trk_valid(trk_valid), .trk_ready(trk_ready), .trk_id(trk_id), .trk_len(trk_len),
        .s_miso_tdata(s_miso_tdata), .s_miso_tvalid(s_miso_tvalid), .s_miso_tready(s_miso_tready),
        .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
        .m_data_tlast(m_data_tlast), .m_data_tid(m_data_tid),
        .resp_done(resp_done), .resp_done_id(resp_done_id),
        .resp_error(resp_error), .err_code(err_code), .err_count(err_count),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] id; logic [15:0] len; } trk_t;
    typedef struct { logic [31:0] word; int need; } miso_t;

    trk_t  trk_pend[$];
    trk_t  mq[$];
    miso_t miso_pend[$];
    int    pushed;
    int    enq_cnt;

    bit         in_data;
    int         rem;
    logic [7:0] cur;
    bit         exp_done;
    logic [7:0] exp_done_id;
    bit         exp_err;
    logic [1:0] exp_code;
    int         exp_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        trk_pend.delete();
        mq.delete();
        miso_pend.delete();
        pushed = 0; enq_cnt = 0;
        in_data = 0; rem = 0; cur = '0;
        exp_done = 0; exp_done_id = '0;
        exp_err = 0; exp_code = '0; exp_cnt = 0;
    endtask

    task automatic model_err(input logic [1:0] code);
        exp_err  = 1;
        exp_code = code;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
    endtask

    task automatic step();
        bit         push_ok;
        logic [31:0] w;
        trk_t       e;
        int         words;
        @(negedge clk);
        trk_valid = 1'b0;
        trk_id    = 8'($urandom);
        trk_len   = 16'($urandom);
        if (trk_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            trk_valid = 1'b1;
            trk_id    = trk_pend[0].id;
            trk_len   = trk_pend[0].len;
        end
        s_miso_tvalid = 1'b0;
        s_miso_tdata  = $urandom;
        if (miso_pend.size() > 0 && miso_pend[0].need <= pushed && $urandom_range(0, 3) != 0) begin
            s_miso_tvalid = 1'b1;
            s_miso_tdata  = miso_pend[0].word;
        end
        m_data_tready = ($urandom_range(0, 3) != 0);
        #1;
        chk("trk_ready", 32'(trk_ready), 32'(mq.size() != 16));
        chk("outstanding", 32'(outstanding), 32'(mq.size()));
        chk("s_miso_tready", 32'(s_miso_tready), in_data ? 32'(m_data_tready) : 32'd1);
        chk("m_tvalid", 32'(m_data_tvalid), 32'(in_data && s_miso_tvalid));
        chk("m_tid", 32'(m_data_tid), 32'(cur));
        if (in_data && s_miso_tvalid) begin
            chk("m_tdata", m_data_tdata, miso_pend[0].word);
            chk("m_tlast", 32'(m_data_tlast), 32'(rem == 1));
        end
        chk("resp_done", 32'(resp_done), 32'(exp_done));
        if (exp_done) chk("resp_done_id", 32'(resp_done_id), 32'(exp_done_id));
        chk("resp_error", 32'(resp_error), 32'(exp_err));
        chk("err_code", 32'(err_code), 32'(exp_code));
        chk("err_count", 32'(err_count), 32'(exp_cnt));

        push_ok  = trk_valid && (mq.size() < 16);
        exp_done = 0;
        exp_err  = 0;
        if (s_miso_tvalid) begin
            if (!in_data) begin
                w = miso_pend[0].word;
                miso_pend.delete(0);
                if (w[31:24] != RESPONSE_MAGIC) begin
                    model_err(2'd1);
                end else if (mq.size() == 0) begin
                    model_err(2'd3);
                end else begin
                    e = mq.pop_front();
                    if (w[23:16] != e.id) model_err(2'd2);
                    cur   = w[23:16];
                    words = (int'(e.len) + 31) / 32;
                    if (words == 0) begin
                        exp_done    = 1;
                        exp_done_id = cur;
                    end else begin
                        in_data = 1;
                        rem     = words;
                    end
                end
            end else if (m_data_tready) begin
                miso_pend.delete(0);
                rem--;
                if (rem == 0) begin
                    in_data     = 0;
                    exp_done    = 1;
                    exp_done_id = cur;
                end
            end
        end
        if (push_ok) begin
            mq.push_back(trk_pend[0]);
            trk_pend.delete(0);
            pushed++;
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((trk_pend.size() > 0 || miso_pend.size() > 0 || in_data) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(trk_pend.size() + miso_pend.size() + int'(in_data)), 32'd0);
    endtask

    task automatic add_cmd(input logic [7:0] id, input logic [15:0] len,
                           input logic [7:0] hid, input bit bad_before);
        logic [31:0] w;
        trk_pend.push_back('{id: id, len: len});
        enq_cnt++;
        if (bad_before) begin
            w = $urandom;
            if (w[31:24] == RESPONSE_MAGIC) w[31:24] = 8'h5A;
            miso_pend.push_back('{word: w, need: enq_cnt});
        end
        w = {RESPONSE_MAGIC, hid, 16'($urandom)};
        miso_pend.push_back('{word: w, need: enq_cnt});
        for (int i = 0; i < (int'(len) + 31) / 32; i++) begin
            miso_pend.push_back('{word: $urandom, need: enq_cnt});
        end
    endtask

    initial begin
        logic [7:0]  id;
        logic [15:0] len;
        logic [7:0]  hid;
        int          n;

        model_reset();
        rstn = 1'b0; trk_valid = 1'b0; trk_id = '0; trk_len = '0;
        s_miso_tvalid = 1'b0; s_miso_tdata = '0; m_data_tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_trk_ready", 32'(trk_ready), 32'd1);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_s_tready", 32'(s_miso_tready), 32'd1);
        chk("rst_m_tvalid", 32'(m_data_tvalid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rstn = 1'b1;

        add_cmd(8'd5, 16'd64, 8'd5, 0);
        run_idle(200);
        add_cmd(8'd3, 16'd33, 8'd3, 0);
        add_cmd(8'd4, 16'd0, 8'd4, 0);
        run_idle(200);
        add_cmd(8'd7, 16'd32, 8'd7, 1);
        run_idle(200);
        add_cmd(8'd8, 16'd32, 8'd9, 0);
        run_idle(200);
        miso_pend.push_back('{word: {RESPONSE_MAGIC, 8'd11, 16'h0}, need: enq_cnt});
        run_idle(200);

        for (int i = 0; i < 16; i++) begin
            trk_pend.push_back('{id: 8'(32 + i), len: 16'd32});
            enq_cnt++;
        end
        run_idle(300);
        trk_pend.push_back('{id: 8'hEE, len: 16'd32});
        repeat (6) step();
        chk("full_ready", 32'(trk_ready), 32'd0);
        chk("full_outstanding", 32'(outstanding), 32'd16);
        trk_pend.delete();
        for (int i = 0; i < 16; i++) begin
            miso_pend.push_back('{word: {RESPONSE_MAGIC, 8'(32 + i), 16'h0}, need: enq_cnt});
            miso_pend.push_back('{word: $urandom, need: enq_cnt});
        end
        run_idle(1000);

        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
                id = 8'($urandom);
                case ($urandom_range(0, 6))
                    0: len = 16'd0;
                    1: len = 16'd1;
                    2: len = 16'd31;
                    3: len = 16'd32;
                    4: len = 16'd33;
                    5: len = 16'd64;
                    default: len = 16'($urandom_range(0, 255));
                endcase
                hid = ($urandom_range(0, 7) == 0) ? (id ^ 8'($urandom_range(1, 255))) : id;
                add_cmd(id, len, hid, $urandom_range(0, 7) == 0);
            end
            run_idle(3000);
        end

        add_cmd(8'h44, 16'd320, 8'h44, 0);
        n = 0;
        while (!(in_data && rem < 8) && n < 500) begin
            step();
            n++;
        end
        chk("reach_data", 32'(in_data), 32'd1);
        #2;
        s_miso_tvalid = 1'b1;
        rstn = 1'b0;
        #1;
        chk("arst_m_tvalid", 32'(m_data_tvalid), 32'd0);
        chk("arst_m_tlast", 32'(m_data_tlast), 32'd0);
        chk("arst_m_tid", 32'(m_data_tid), 32'd0);
        chk("arst_s_tready", 32'(s_miso_tready), 32'd1);
        chk("arst_outstanding", 32'(outstanding), 32'd0);
        chk("arst_trk_ready", 32'(trk_ready), 32'd1);
        chk("arst_done", 32'(resp_done), 32'd0);
        chk("arst_error", 32'(resp_error), 32'd0);
        chk("arst_err_code", 32'(err_code), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        s_miso_tvalid = 1'b0;
        trk_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        add_cmd(8'h21, 16'd96, 8'h21, 0);
        run_idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piradspi_resp_tracker.md
# piradspi_resp_tracker

Response tracker that sits directly downstream of the SPI engine's MISO word stream, before the host-facing MISO FIFO. For every command the engine accepts, the tracker is told the command id and transfer length, then parses the engine output: it validates and strips the response header word, then forwards exactly ceil(xfer_len/DATA_WIDTH) data words tagged with the command id and `tlast`. It reports per-command completion and framing errors, and resynchronises on a corrupted stream.

## Interface
- DATA_WIDTH, 32: MISO word width; must be a power of two ≥ MAGIC_WIDTH+CMD_ID_WIDTH.
- TRK_DEPTH, 16: tracking FIFO entries; power of two; matches the command FIFO depth.
- clk  input  1  block clock.
- rstn  input  1  reset; one clock; reset is asynchronous and active-low.
- trk_valid  input  1  command accepted by engine, id/len valid.
- trk_ready  output  1  tracking FIFO not full.
- trk_id  input  CMD_ID_WIDTH  command id (piradspi package width).
- trk_len  input  $bits(xfer_len_t)  transfer length in bits.
- s_miso_tdata  input  DATA_WIDTH  engine output word.
- s_miso_tvalid  input  1  word valid.
- s_miso_tready  output  1  word accepted.
- m_data_tdata  output  DATA_WIDTH  forwarded data word.
- m_data_tvalid  output  1  forwarded word valid.
- m_data_tready  input  1  downstream ready.
- m_data_tlast  output  1  last word of a command.
- m_data_tid  output  CMD_ID_WIDTH  id of the command the word belongs to.
- resp_done  output  1  one-cycle pulse: command fully forwarded.
- resp_done_id  output  CMD_ID_WIDTH  id for resp_done.
- resp_error  output  1  one-cycle pulse: framing error.
- err_code  output  2  1 = bad magic, 2 = id mismatch, 3 = orphan header; held until next error.
- err_count  output  16  saturating error counter.
- outstanding  output  $clog2(TRK_DEPTH+1)  tracking FIFO occupancy.

## Operation
- Tracking FIFO: push on trk_valid & trk_ready; pop on header acceptance. trk_ready = (outstanding != TRK_DEPTH) from registered count; a push is refused at full even if a pop occurs in the same cycle. Simultaneous push/pop below full leaves outstanding unchanged.
- Header word layout: top MAGIC_WIDTH bits = magic, next CMD_ID_WIDTH bits = id, low bits pad (ignored).
- State HDR: s_miso_tready = 1, m_data_tvalid = 0. On accepted word:
  - magic != RESPONSE_MAGIC: drop word, error code 1, no pop, stay HDR (resync).
  - magic ok, FIFO empty: drop, error code 3, stay HDR.
  - magic ok, id != head id: error code 2, pop, continue as below using head length and received id.
  - magic ok, id matches: pop, latch id, words = (len + DATA_WIDTH-1) >> log2(DATA_WIDTH) in width $bits(xfer_len_t)+1. words == 0: schedule resp_done, stay HDR; else go DATA.
- State DATA: combinational pass-through: m_data_tvalid = s_miso_tvalid, s_miso_tready = m_data_tready, m_data_tdata = s_miso_tdata, m_data_tid = latched id, m_data_tlast = (remaining == 1). Decrement remaining on each handshake; handshake with remaining == 1 schedules resp_done and returns to HDR. No magic checking in DATA.
- err_count increments once per error, saturates at 0xFFFF.

## Timing
- Reset values: state HDR, FIFO empty, outstanding 0, trk_ready 1, s_miso_tready 1 (state HDR), m_data_tvalid 0, m_data_tlast 0, m_data_tid 0, resp_done 0, resp_done_id 0, resp_error 0, err_code 0, err_count 0. Reset mid-command discards the tracking FIFO and the partially forwarded command; no done/error pulse.
- Header costs exactly one accepted beat, no output. Data latency zero cycles (combinational).
- resp_done/resp_done_id and resp_error register: asserted the cycle after the triggering handshake, for one cycle.
- Back-to-back: the header of the next command is accepted the cycle after the last data handshake.
- outstanding updates the cycle after push/pop.
- A trk push and header pop for the same entry in the same cycle: the header sees FIFO empty → error code 3 (tracker must be fed before the engine emits the header; the engine's FIFO ordering guarantees this).

## Test plan
- Push (id 5, len 64); send header {RESPONSE_MAGIC, 5} then 2 words -> two m_data beats, tid 5, tlast on 2nd, resp_done pulse with id 5, err_count 0.
- Push (id 3, len 33) -> header + 2 words forwarded; (id 4, len 0) -> header only, resp_done id 4 one cycle after header, no m_data beat.
- Send word with bad magic, then valid header for queued id 7 len 32 -> resp_error code 1, word dropped, then one data beat tid 7 tlast.
- Header id 9 with head id 8 len 32 -> resp_error code 2, one data beat, tid 9, FIFO popped; header with empty FIFO -> code 3, outstanding stays 0.
- Push 16 entries -> trk_ready 0, 17th push ignored; random m_data_tready stalls -> no beat lost or duplicated; async reset mid-DATA -> all outputs return to reset values immediately.
